// File: rtl/riscv_pkg.sv
// riscv_pkg: definitions shared by the RV64 pipeline control blocks.
//   - MEM-stage sequencer state encoding (IDLE/BUSY/DONE), 2-bit constants
//   - XLEN: datapath width
//   - RESULT_SRC_BUBBLE: ResultSrc value carried by a MEM/WB bubble
package riscv_pkg;

    localparam int XLEN = 64;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] BUSY = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

    localparam logic [1:0] RESULT_SRC_BUBBLE = 2'b00;

endpackage

// File: rtl/mem_timeout_ctr.sv
// mem_timeout_ctr: 16-bit watchdog counter for an outstanding data memory access.
// Ports:
//   clk      in   clock
//   rst      in   synchronous, active-high reset
//   clear    in   restart the count (start of a new access)
//   count_en in   access still pending this cycle (BUSY and no ack)
//   expired  out  this pending cycle is the LIMIT-th one without an ack
module mem_timeout_ctr #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    logic [15:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= 16'd0;
        end else if (count_en) begin
            count <= count + 16'd1;
        end
    end

    // count holds the number of pending cycles already completed, so the
    // LIMIT-th pending cycle sees LIMIT-1.
    assign expired = count_en && (count == 16'(LIMIT - 1));

endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage sequencer. Converts a load/store in MEM into a
// req/ack transaction on a variable-latency data memory port, freezes the
// upstream stages and bubbles MEM/WB while the access is pending, and holds the
// returned load data for the MEM/WB register.
//
// Optional feature: define MEM_TIMEOUT_EN to add a watchdog that aborts a
// BUSY access after TIMEOUT_CYCLES cycles without ack (mem_err pulse, load
// data forced to 0). Without it, mem_err is tied to 0.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   MemReqM, MemWriteM          MEM instruction is a load/store, 1 = store
//   ALUResultM, WriteDataM      effective address, store data
//   dmem_req/we/addr/wdata      registered request to data memory
//   dmem_ack, dmem_rdata        completion pulse and load data
//   ReadDataM                   held load data to MEM/WB
//   StallF/D/E/M, FlushW        upstream freeze and MEM/WB bubble
//   mem_err                     timeout pulse (DONE cycle)
module mem_stage_ctrl
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            MemReqM,
    input  logic            MemWriteM,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] WriteDataM,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic [XLEN-1:0] ReadDataM,
    output logic            StallF,
    output logic            StallD,
    output logic            StallE,
    output logic            StallM,
    output logic            FlushW,
    output logic            mem_err
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("mem_stage_ctrl: TIMEOUT_CYCLES must be within 1..65535");
    end

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       start;
    logic       timeout;
    logic       hold;

    assign start = (state == IDLE) && MemReqM;

`ifdef MEM_TIMEOUT_EN
    logic expired;
    logic err_q;

    mem_timeout_ctr #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk     (clk),
        .rst     (rst),
        .clear   (start),
        .count_en((state == BUSY) && !dmem_ack),
        .expired (expired)
    );

    // count_en already excludes ack cycles, so a same-cycle ack wins.
    assign timeout = expired;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (state == BUSY) && timeout;
        end
    end

    assign mem_err = err_q;
`else
    assign timeout = 1'b0;
    assign mem_err = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (MemReqM) state_nxt = BUSY;
            BUSY:    if (dmem_ack || timeout) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            ReadDataM  <= '0;
        end else begin
            state    <= state_nxt;
            // Request is high for exactly the BUSY cycles.
            dmem_req <= (state_nxt == BUSY);
            if (start) begin
                dmem_we    <= MemWriteM;
                dmem_addr  <= ALUResultM;
                dmem_wdata <= WriteDataM;
            end
            // dmem_we still describes the in-flight access during BUSY.
            if (state == BUSY && !dmem_we) begin
                if (dmem_ack) begin
                    ReadDataM <= dmem_rdata;
                end else if (timeout) begin
                    ReadDataM <= '0;
                end
            end
        end
    end

    // The instruction must wait in MEM from the cycle it arrives until its ack.
    assign hold   = start || (state == BUSY);
    assign StallF = hold;
    assign StallD = hold;
    assign StallE = hold;
    assign StallM = hold;
    assign FlushW = hold;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: directed self-checking bench for mem_stage_ctrl.
// Inputs change 2 time units after the rising edge; outputs are sampled on
// the falling edge.
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemReqM, MemWriteM;
    logic [63:0] ALUResultM, WriteDataM;
    logic        dmem_req, dmem_we;
    logic [63:0] dmem_addr, dmem_wdata;
    logic        dmem_ack;
    logic [63:0] dmem_rdata;
    logic [63:0] ReadDataM;
    logic        StallF, StallD, StallE, StallM, FlushW;
    logic        mem_err;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    mem_stage_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .MemReqM   (MemReqM),
        .MemWriteM (MemWriteM),
        .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM),
        .dmem_req  (dmem_req),
        .dmem_we   (dmem_we),
        .dmem_addr (dmem_addr),
        .dmem_wdata(dmem_wdata),
        .dmem_ack  (dmem_ack),
        .dmem_rdata(dmem_rdata),
        .ReadDataM (ReadDataM),
        .StallF    (StallF),
        .StallD    (StallD),
        .StallE    (StallE),
        .StallM    (StallM),
        .FlushW    (FlushW),
        .mem_err   (mem_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic go();
        @(posedge clk);
        #2;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    function automatic logic [4:0] ctl();
        return {StallF, StallD, StallE, StallM, FlushW};
    endfunction

    // One complete transaction, acked in BUSY cycle k. Caller is at a
    // drive point with the FSM in IDLE; returns at a drive point in IDLE.
    task automatic txn(input string tag, input logic we, input logic [63:0] addr,
                       input logic [63:0] wdata, input int k,
                       input logic [63:0] rdata, input logic [63:0] exp_rd);
        int stall_n = 0;
        int req_n   = 0;
        MemReqM    = 1'b1;
        MemWriteM  = we;
        ALUResultM = addr;
        WriteDataM = wdata;
        look();
        if (StallF) stall_n++;
        if (dmem_req) req_n++;
        chk({tag, "_ctl0"}, 64'(ctl()), 64'h1f);
        go();
        // Upstream is frozen: scramble the live MEM operands to prove the
        // latched request does not follow them.
        ALUResultM = ~addr;
        WriteDataM = ~wdata;
        MemWriteM  = ~we;
        for (int i = 1; i <= k; i++) begin
            if (i == k) begin
                dmem_ack   = 1'b1;
                dmem_rdata = rdata;
            end
            look();
            if (StallF) stall_n++;
            if (dmem_req) req_n++;
            if (i == 1) begin
                chk({tag, "_addr"},  dmem_addr, addr);
                chk({tag, "_we"},    64'(dmem_we), 64'(we));
                chk({tag, "_wdata"}, dmem_wdata, wdata);
            end
            go();
            dmem_ack   = 1'b0;
            dmem_rdata = 64'h0;
        end
        // DONE: instruction still in MEM, request must be ignored.
        MemReqM = 1'b1;
        look();
        chk({tag, "_done_ctl"}, 64'(ctl()), 64'h0);
        chk({tag, "_done_req"}, 64'(dmem_req), 64'h0);
        chk({tag, "_rdata"},    ReadDataM, exp_rd);
        chk({tag, "_err"},      64'(mem_err), 64'h0);
        chk({tag, "_nstall"},   64'(stall_n), 64'(k + 1));
        chk({tag, "_nreq"},     64'(req_n), 64'(k));
        go();
        MemReqM = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        MemReqM    = 1'b0;
        MemWriteM  = 1'b0;
        ALUResultM = 64'h0;
        WriteDataM = 64'h0;
        dmem_ack   = 1'b0;
        dmem_rdata = 64'h0;
        go();
        go();
        look();
        chk("rst_ctl",  64'(ctl()), 64'h0);
        chk("rst_req",  64'(dmem_req), 64'h0);
        chk("rst_addr", dmem_addr, 64'h0);
        chk("rst_rd",   ReadDataM, 64'h0);
        chk("rst_err",  64'(mem_err), 64'h0);
        go();
        rst = 1'b0;
        go();

        // Load, ack after 3 BUSY cycles: 4 stall cycles, 3 req cycles.
        txn("ld1", 1'b0, 64'h1000, 64'h0, 3, 64'hDEADBEEF_CAFEF00D, 64'hDEADBEEF_CAFEF00D);
        look();
        chk("ld1_idle_ctl", 64'(ctl()), 64'h0);
        go();

        // Store acked at the first BUSY cycle; rdata on the bus is not taken.
        txn("st1", 1'b1, 64'h2008, 64'h55, 1, 64'h1234, 64'hDEADBEEF_CAFEF00D);

        // Back-to-back loads: second starts in the IDLE cycle after DONE.
        txn("bb1", 1'b0, 64'h3000, 64'h0, 1, 64'h1111_2222_3333_4444, 64'h1111_2222_3333_4444);
        txn("bb2", 1'b0, 64'h3008, 64'h0, 1, 64'h5555_6666_7777_8888, 64'h5555_6666_7777_8888);

        // Spurious ack while IDLE.
        dmem_ack   = 1'b1;
        dmem_rdata = 64'hFF;
        look();
        chk("spur_ctl", 64'(ctl()), 64'h0);
        go();
        dmem_ack   = 1'b0;
        dmem_rdata = 64'h0;
        look();
        chk("spur_rd",  ReadDataM, 64'h5555_6666_7777_8888);
        chk("spur_req", 64'(dmem_req), 64'h0);
        chk("spur_ctl2", 64'(ctl()), 64'h0);
        go();

        // Reset during the second BUSY cycle, then a late ack.
        MemReqM    = 1'b1;
        MemWriteM  = 1'b0;
        ALUResultM = 64'h4000;
        go();
        look();
        chk("rmid_busy1_req", 64'(dmem_req), 64'h1);
        go();
        rst = 1'b1;
        look();
        chk("rmid_busy2_req", 64'(dmem_req), 64'h1);
        go();
        rst     = 1'b0;
        MemReqM = 1'b0;
        look();
        chk("rmid_req",  64'(dmem_req), 64'h0);
        chk("rmid_ctl",  64'(ctl()), 64'h0);
        chk("rmid_addr", dmem_addr, 64'h0);
        go();
        dmem_ack   = 1'b1;
        dmem_rdata = 64'h77;
        go();
        dmem_ack   = 1'b0;
        dmem_rdata = 64'h0;
        look();
        chk("rmid_late_rd",  ReadDataM, 64'h0);
        chk("rmid_late_req", 64'(dmem_req), 64'h0);
        chk("rmid_late_ctl", 64'(ctl()), 64'h0);
        go();

        // Normal operation after reset.
        txn("post", 1'b0, 64'h5000, 64'h0, 2, 64'hA5A5_0000_FFFF_1234, 64'hA5A5_0000_FFFF_1234);

`ifdef MEM_TIMEOUT_EN
        // Load with no ack: aborted after 4 BUSY cycles.
        MemReqM    = 1'b1;
        MemWriteM  = 1'b0;
        ALUResultM = 64'h6000;
        look();
        chk("to_ctl0", 64'(ctl()), 64'h1f);
        go();
        for (int i = 1; i <= 4; i++) begin
            look();
            chk("to_busy_req", 64'(dmem_req), 64'h1);
            chk("to_busy_err", 64'(mem_err), 64'h0);
            go();
        end
        look();
        chk("to_err",  64'(mem_err), 64'h1);
        chk("to_rd",   ReadDataM, 64'h0);
        chk("to_req",  64'(dmem_req), 64'h0);
        chk("to_ctl",  64'(ctl()), 64'h0);
        go();
        MemReqM = 1'b0;
        look();
        chk("to_err_pulse", 64'(mem_err), 64'h0);
        go();

        // Ack in the 4th BUSY cycle beats the timeout.
        txn("to_ack4", 1'b0, 64'h6008, 64'h0, 4, 64'hBEEF, 64'hBEEF);
`else
        txn("long", 1'b0, 64'h6008, 64'h0, 6, 64'hBEEF, 64'hBEEF);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
